flash_read_streamer: RTL

- Upstream sequencer for the flash controller. Turns one "read N words from address A" request into back-to-back single-word CMD_READ transactions.
- Captures each returned word into a small FIFO and presents it on a valid/ready stream, for example to a boot loader or an SDRAM copy engine.
- Keeps at most one read outstanding. It never issues a read unless the FIFO has room for the result.

---
 rtl/flash_cmd_pkg.sv | 28 ++
 rtl/flash_stream_fifo.sv | 79 +++++++
 rtl/flash_read_streamer.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/flash_cmd_pkg.sv
// -----------------------------------------------------------------------------
// flash_cmd_pkg
//   Shared definitions for the flash controller and its read streamer:
//   - 4-bit command codes understood by the flash controller
//   - state encoding of flash_read_streamer
// -----------------------------------------------------------------------------
package flash_cmd_pkg;

    // Controller command codes. CMD_READ is 0 so a reset command register
    // already holds a harmless read opcode.
    localparam logic [3:0] CMD_READ     = 4'h0;
    localparam logic [3:0] CMD_WRITE    = 4'h1;
    localparam logic [3:0] CMD_BLK_ERA  = 4'h2;
    localparam logic [3:0] CMD_SEC_ERA  = 4'h3;
    localparam logic [3:0] CMD_CHP_ERA  = 4'h4;
    localparam logic [3:0] CMD_ENTRY_ID = 4'h5;
    localparam logic [3:0] CMD_RESET    = 4'h6;

    // Streamer FSM encoding.
    typedef logic [2:0] stream_state_t;

    localparam stream_state_t ST_IDLE    = 3'd0;
    localparam stream_state_t ST_ISSUE   = 3'd1;
    localparam stream_state_t ST_WAIT_LO = 3'd2;
    localparam stream_state_t ST_WAIT_HI = 3'd3;
    localparam stream_state_t ST_CAPTURE = 3'd4;

endpackage

// File: rtl/flash_stream_fifo.sv
// -----------------------------------------------------------------------------
// flash_stream_fifo
//   Synchronous first-word-fall-through FIFO holding words returned by the
//   flash controller until the stream consumer takes them.
//
//   Ports:
//     iCLK, iRST  clock, asynchronous active-high reset
//     push        write wr_data (ignored when full unless popping too)
//     pop         remove head word (ignored when empty)
//     wr_data     word to write
//     rd_data     head word; undefined-but-stable while empty
//     flush       discard all entries (wins over push and pop)
//     count       current occupancy, 0..DEPTH
//     full        count == DEPTH
//     empty       count == 0
// -----------------------------------------------------------------------------
module flash_stream_fifo #(
    parameter int DEPTH = 8,    // power of two, >= 2
    parameter int WIDTH = 16
) (
    input  logic                     iCLK,
    input  logic                     iRST,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (PTR_W + 1)'(DEPTH));
    assign count   = count_q;
    assign rd_data = mem[rd_ptr];

    // A pop frees the slot a same-cycle push into a full FIFO needs.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // NOTE: the storage array has no reset; only pointers and occupancy define
    // what is valid, and leaving the array unreset lets it map onto RAM.
    always_ff @(posedge iCLK) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/flash_read_streamer.sv
// -----------------------------------------------------------------------------
// flash_read_streamer
//   Turns one "read N words from address A" request into back-to-back
//   single-word CMD_READ transactions on the flash controller, buffers the
//   returned words in a FIFO and presents them on a valid/ready stream.
//   At most one read is outstanding, and a read is only issued when the FIFO
//   has room for its result.
//
//   Ports:
//     iCLK, iRST          clock, asynchronous active-high reset
//     iGO                 request strobe, ignored while oBUSY
//     iSTART_ADDR         first word address, sampled on accepted iGO
//     iWORD_CNT           number of words, sampled on accepted iGO
//     iABORT              cancel request and flush FIFO
//     oBUSY               request in progress
//     oDONE               one-cycle pulse for the last word
//     oERR                sticky controller timeout flag
//     oTDATA/oTVALID/iTREADY  output word stream
//     oFL_CMD/oFL_ADDR/oFL_START  command side of the flash controller
//     iFL_DATA/iFL_READY  response side of the flash controller
// -----------------------------------------------------------------------------
module flash_read_streamer
    import flash_cmd_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT    = 1023,
    parameter int ADDR_W     = 22
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iGO,
    input  logic [ADDR_W-1:0] iSTART_ADDR,
    input  logic [ADDR_W-1:0] iWORD_CNT,
    input  logic              iABORT,
    output logic              oBUSY,
    output logic              oDONE,
    output logic              oERR,
    output logic [15:0]       oTDATA,
    output logic              oTVALID,
    input  logic              iTREADY,
    output logic [3:0]        oFL_CMD,
    output logic [ADDR_W-1:0] oFL_ADDR,
    output logic              oFL_START,
    input  logic [15:0]       iFL_DATA,
    input  logic              iFL_READY
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int TMR_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT);

    stream_state_t     state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] rem_q;
    logic [TMR_W-1:0]  timer_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic              fl_start_q;
    logic [3:0]        fl_cmd_q;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W-1:0]  fifo_free;

    assign fifo_free = CNT_W'(FIFO_DEPTH) - fifo_count;
    assign fifo_pop  = !fifo_empty && iTREADY;
    // An abort in CAPTURE discards the word; the full guard only protects
    // against overwriting, since ISSUE already waited for a free slot.
    assign fifo_push = (state_q == ST_CAPTURE) && !iABORT && !fifo_full;

    flash_stream_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .iCLK    (iCLK),
        .iRST    (iRST),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wr_data (iFL_DATA),
        .rd_data (oTDATA),
        .flush   (iABORT),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            timer_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            fl_start_q <= 1'b0;
            fl_cmd_q   <= CMD_READ;
        end else begin
            // Strobes default low so each is a single-cycle pulse.
            fl_start_q <= 1'b0;
            done_q     <= 1'b0;

            if (iABORT) begin
                // Any in-flight controller read finishes on its own; its data
                // is never captured because the FSM is no longer waiting.
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        // busy_q is still high here for one cycle after a
                        // zero-count request, which also blocks a new iGO.
                        busy_q <= 1'b0;
                        if (iGO && !busy_q) begin
                            addr_q <= iSTART_ADDR;
                            rem_q  <= iWORD_CNT;
                            err_q  <= 1'b0;
                            busy_q <= 1'b1;
                            if (iWORD_CNT == '0) begin
                                done_q <= 1'b1;
                            end else begin
                                state_q <= ST_ISSUE;
                            end
                        end
                    end

                    ST_ISSUE: begin
                        if (fifo_free != '0) begin
                            fl_start_q <= 1'b1;
                            timer_q    <= '0;
                            state_q    <= ST_WAIT_LO;
                        end
                    end

                    ST_WAIT_LO: begin
                        if (!iFL_READY) begin
                            timer_q <= '0;
                            state_q <= ST_WAIT_HI;
                        end else if (timer_q == TMR_LIMIT) begin
                            err_q   <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end else begin
                            timer_q <= timer_q + 1'b1;
                        end
                    end

                    ST_WAIT_HI: begin
                        if (iFL_READY) begin
                            // Raise oDONE during the CAPTURE cycle of the
                            // last word.
                            done_q  <= (rem_q == ADDR_W'(1));
                            state_q <= ST_CAPTURE;
                        end else if (timer_q == TMR_LIMIT) begin
                            err_q   <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end else begin
                            timer_q <= timer_q + 1'b1;
                        end
                    end

                    ST_CAPTURE: begin
                        addr_q <= addr_q + 1'b1;  // wraps modulo 2^ADDR_W
                        rem_q  <= rem_q - 1'b1;
                        if (rem_q == ADDR_W'(1)) begin
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end else begin
                            state_q <= ST_ISSUE;
                        end
                    end

                    default: begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // addr_q only changes at the end of CAPTURE, so driving the controller
    // address straight from it keeps it stable from ISSUE through CAPTURE.
    assign oFL_ADDR  = addr_q;
    assign oFL_CMD   = fl_cmd_q;
    assign oFL_START = fl_start_q;
    assign oBUSY     = busy_q;
    assign oDONE     = done_q;
    assign oERR      = err_q;
    assign oTVALID   = !fifo_empty;

endmodule
